// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register map: CTRL, PRESET, COUNT (read-only) selected by Addr[3:2].
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  ctrl;
    logic [3:0]  ctrlNext;
    logic [31:0] preset;
    logic [31:0] presetNext;
    logic [31:0] count;
    logic [31:0] countNext;
    logic        irqFlag;
    logic        flagNext;

    logic ctrlWr;
    logic presetWr;
    logic enable;
    logic autoReload;
    logic unusedBits;

    assign ctrlWr     = WE && (Addr[3:2] == 2'd0);
    assign presetWr   = WE && (Addr[3:2] == 2'd1);
    assign enable     = ctrl[0];
    assign autoReload = (ctrl[2:1] == 2'b01);
    assign unusedBits = ^{Addr[1:0], DIn[31:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ctrl    <= 4'h0;
            preset  <= PRESET_RST;
            count   <= 32'h0;
            irqFlag <= 1'b0;
        end else begin
            state   <= stateNext;
            ctrl    <= ctrlNext;
            preset  <= presetNext;
            count   <= countNext;
            irqFlag <= flagNext;
        end
    end

    always_comb begin
        stateNext  = state;
        ctrlNext   = ctrl;
        presetNext = preset;
        countNext  = count;
        flagNext   = irqFlag;
        case (state)
            IDLE: begin
                if (enable) stateNext = LOAD;
            end
            LOAD: begin
                countNext = preset;
                stateNext = CNT;
            end
            CNT: begin
                if (!enable) begin
                    stateNext = IDLE;
                end else if (count <= 32'd1) begin
                    countNext = 32'h0;
                    flagNext  = 1'b1;
                    stateNext = INT;
                end else begin
                    countNext = count - 32'd1;
                end
            end
            INT: begin
                if (autoReload) begin
                    flagNext  = 1'b0;
                    stateNext = LOAD;
                end else begin
                    ctrlNext[0] = 1'b0;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (presetWr) begin
            presetNext = DIn;
            flagNext   = 1'b0;
        end
        // CTRL write overrides every FSM action, including a pending auto-clear of Enable
        if (ctrlWr) begin
            ctrlNext  = DIn[3:0];
            stateNext = IDLE;
            countNext = count;
            flagNext  = 1'b0;
        end
    end

    always_comb begin
        DOut = 32'h0;
        case (Addr[3:2])
            2'd0:    DOut = {28'h0, ctrl};
            2'd1:    DOut = preset;
            2'd2:    DOut = count;
            default: DOut = 32'h0;
        endcase
    end

    assign IRQ = ctrl[3] & irqFlag;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped down-counting timer on the CPU's peripheral bus.
- Sits directly downstream of the CPU-to-device bridge as device 0 (base 0x7F00). It consumes the bridge's device address, write data and per-device write enable, and returns read data and an interrupt request to the CPU.
- Supports one-shot and auto-reload modes, with a maskable interrupt.

Parameters:
- PRESET_RST, 32'h0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  4  byte offset within the device window; only Addr[3:2] is decoded.
- WE  input  1  write enable for this device, already qualified by address hit.
- DIn  input  32  write data.
- DOut  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request to the CPU.

Behaviour:
Register map (Addr[3:2]):
- 0 CTRL, read/write. Bit 3 is IM (interrupt mask, 1 = enabled); bits 2:1 are Mode (00 one-shot, 01 auto-reload, 1x treated as 00); bit 0 is Enable. Bits 31:4 are not stored and read as 0.
- 1 PRESET, read/write, 32 bits.
- 2 COUNT, read-only. Writes to it are ignored.
- 3 unmapped. Reads return 0; writes are ignored.

Reset:
- CTRL = 0, PRESET = PRESET_RST, COUNT = 0.
- State = IDLE, irq_flag = 0, IRQ = 0.
- Reset overrides any write in the same cycle. Reset mid-count aborts the count immediately.

Writes:
- Take effect at the edge where WE = 1.
- A CTRL write forces the next state to IDLE and clears irq_flag.
- A PRESET write clears irq_flag. It does not alter a count in progress; the new value is used at the next LOAD.

State machine (one transition per clock; a CTRL write overrides the transitions below):
- IDLE: if Enable = 1, go to LOAD. COUNT holds.
- LOAD: COUNT <= PRESET, go to CNT.
- CNT:
  - If Enable = 0, go to IDLE with COUNT held.
  - Else if COUNT <= 1: COUNT <= 0, irq_flag <= 1, go to INT.
  - Else COUNT <= COUNT - 1.
- INT:
  - Mode one-shot: Enable <= 0, go to IDLE, irq_flag stays set (sticky) until a CTRL or PRESET write.
  - Mode auto-reload: irq_flag <= 0, go to LOAD.

Timing and boundary rules:
- IRQ = IM & irq_flag, registered-derived with no combinational path from DIn.
- Auto-reload period = PRESET + 2 cycles, and IRQ pulses for exactly 1 cycle per period.
- PRESET = 0 or 1: LOAD then CNT reaches INT on the next edge, with no underflow. COUNT never wraps below 0.
- In INT under one-shot mode, a simultaneous CTRL write wins: its Enable value is stored rather than the forced clear.
- Clearing Enable mid-count freezes COUNT. Re-enabling restarts from LOAD, not from the frozen value.
- IM = 0 masks IRQ but irq_flag still sets. Raising IM later asserts IRQ if irq_flag is still set, which cannot happen via a CTRL write because that write clears irq_flag; the flag is therefore visible only through PRESET-untouched one-shot completion.
- DOut depends only on current Addr and register state. Reads have no side effects.

Test Plan:
- Reset with PRESET_RST = 0: DOut at Addr 0/4/8 reads 0/0/0 and IRQ = 0. Write CTRL 0xFFFFFFFF then read it: 0x0000000F.
- One-shot: PRESET = 5, then CTRL = 0x9 written at edge E0. COUNT reads 5, 4, 3, 2, 1 after edges E0+2 through E0+6, and 0 after E0+7. IRQ = 1 from E0+7 and stays high. CTRL reads 0x8 after E0+8.
- Auto-reload: PRESET = 5, CTRL = 0xB at E0. IRQ is high only in the cycles after E0+7, E0+14 and E0+21, and low elsewhere.
- Masking and clear: one-shot with CTRL = 0x1, PRESET = 3. IRQ stays 0 throughout, and COUNT ends at 0 with CTRL reading 0x0. Repeat with IM = 1 and, after IRQ rises, write PRESET = 7: IRQ drops the next cycle.
- Pause and edge values: PRESET = 10, enable, then after COUNT = 6 write CTRL = 0x0. COUNT holds 6 for 5 cycles. Then write PRESET = 0 and CTRL = 0x9: IRQ rises 3 edges after the CTRL write, and COUNT never exceeds 0.
- Ignored writes and reset mid-count: a write of 0x55 to Addr 8 or Addr 0xC leaves COUNT unchanged, and Addr 0xC reads 0. Assert reset during CNT: all outputs are 0 next cycle and the state returns to IDLE.
